// File: rtl/alu_input_ctrl.sv
// alu_input_ctrl
// Input-side front end for the ALU board wrapper. The block synchronises and
// debounces the pushbuttons and turns each press into a one-cycle pulse. It
// steps through entry of operand A, operand B and the opcode, then presents
// the latched set on a valid/ready handshake.
module alu_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [3:0]  key_n,
  input  logic [17:0] sw,
  output logic [31:0] port_a,
  output logic [31:0] port_b,
  output logic [3:0]  aluop,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [1:0]  state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_OP    = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  // Two-flop synchronisers. Keys idle high (released), switches idle low.
  logic [3:0]       key_sync1_q, key_sync2_q;
  logic [17:0]      sw_sync1_q, sw_sync2_q;

  // Debounce state, one counter per key.
  logic [3:0]       key_stable_q, key_stable_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // One-cycle press pulses. Each is registered on the edge where the stable
  // value falls.
  logic [3:0]       press_q, press_d;

  // Operand registers and the sequencer.
  state_t           state_q, state_d;
  logic [31:0]      port_a_q, port_a_d;
  logic [31:0]      port_b_q, port_b_d;
  logic [3:0]       aluop_q, aluop_d;
  logic             op_valid_q, op_valid_d;

  logic [31:0]      operand_s;
  logic             enter_s, cancel_s, repeat_s, clear_s;
  logic             sw_unused_s;

  // The top switch has no function. It is kept so that the synchroniser
  // matches the port.
  assign sw_unused_s = sw_sync2_q[17];

  assign enter_s  = press_q[0];
  assign cancel_s = press_q[1];
  assign repeat_s = press_q[2];
  assign clear_s  = press_q[3];

  // sw[16] selects sign-fill of the upper half. The value comes from the
  // synchronised switches.
  assign operand_s = sw_sync2_q[16] ? {16'hFFFF, sw_sync2_q[15:0]}
                                    : {16'h0000, sw_sync2_q[15:0]};

  // Synchroniser flops for the raw key and switch inputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      key_sync1_q <= 4'hF;
      key_sync2_q <= 4'hF;
      sw_sync1_q  <= 18'h00000;
      sw_sync2_q  <= 18'h00000;
    end else begin
      key_sync1_q <= key_n;
      key_sync2_q <= key_sync1_q;
      sw_sync1_q  <= sw;
      sw_sync2_q  <= sw_sync1_q;
    end
  end

  // Debounce: a change is accepted only after the synced value has differed
  // from the stable value for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    key_stable_d = key_stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (key_sync2_q[i] != key_stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          key_stable_d[i] = key_sync2_q[i];
          cnt_d[i]        = {CNT_W{1'b0}};
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = {CNT_W{1'b0}};
      end
    end
    press_d = key_stable_q & ~key_stable_d;
  end

  // Debounce state and press pulse registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      key_stable_q <= 4'hF;
      press_q      <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      key_stable_q <= key_stable_d;
      press_q      <= press_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Sequencer next-state and register updates.
  // Simultaneous pulses are resolved as clear > cancel > enter > repeat.
  always_comb begin
    state_d  = state_q;
    port_a_d = port_a_q;
    port_b_d = port_b_q;
    aluop_d  = aluop_q;
    case (state_q)
      S_A: begin
        if (clear_s) begin
          port_a_d = 32'h0000_0000;
          port_b_d = 32'h0000_0000;
          aluop_d  = 4'h0;
          state_d  = S_A;
        end else if (cancel_s) begin
          state_d = S_A;
        end else if (enter_s) begin
          port_a_d = operand_s;
          state_d  = S_B;
        end else if (repeat_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_A;
        end
      end
      S_B: begin
        if (clear_s) begin
          port_a_d = 32'h0000_0000;
          port_b_d = 32'h0000_0000;
          aluop_d  = 4'h0;
          state_d  = S_A;
        end else if (cancel_s) begin
          state_d = S_A;
        end else if (enter_s) begin
          port_b_d = operand_s;
          state_d  = S_OP;
        end else begin
          state_d = S_B;
        end
      end
      S_OP: begin
        if (clear_s) begin
          port_a_d = 32'h0000_0000;
          port_b_d = 32'h0000_0000;
          aluop_d  = 4'h0;
          state_d  = S_A;
        end else if (cancel_s) begin
          state_d = S_A;
        end else if (enter_s) begin
          aluop_d = sw_sync2_q[3:0];
          state_d = S_ISSUE;
        end else begin
          state_d = S_OP;
        end
      end
      S_ISSUE: begin
        // Key pulses are dropped here. The operand set is frozen until the
        // consumer accepts it.
        if (op_ready) begin
          state_d = S_A;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
    op_valid_d = (state_d == S_ISSUE);
  end

  // Sequencer and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_A;
      port_a_q   <= 32'h0000_0000;
      port_b_q   <= 32'h0000_0000;
      aluop_q    <= 4'h0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_a_q   <= port_a_d;
      port_b_q   <= port_b_d;
      aluop_q    <= aluop_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign port_a   = port_a_q;
  assign port_b   = port_b_q;
  assign aluop    = aluop_q;
  assign op_valid = op_valid_q;
  assign state    = state_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Self-checking bench for alu_input_ctrl with DEBOUNCE_CYCLES=4.
// Each expected operand set is queued when the final keypress is driven.
// The set is checked against the outputs at the handshake.
`timescale 1ns/1ps
module tb_alu_input_ctrl;

  logic        CLK;
  logic        nRST;
  logic [3:0]  key_n;
  logic [17:0] sw;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic [3:0]  aluop;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  // {port_a, port_b, aluop}
  logic [67:0] sb_q [$];
  logic [67:0] sb_exp;

  alu_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .key_n    (key_n),
    .sw       (sw),
    .port_a   (port_a),
    .port_b   (port_b),
    .aluop    (aluop),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .state    (state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after a rising edge. Inputs change only here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Press the keys in mask (1 = pressed), hold them, release them, then let the release debounce.
  task automatic press(input logic [3:0] mask);
    tick();
    key_n = ~mask;
    repeat (10) tick();
    key_n = 4'hF;
    repeat (10) tick();
  endtask

  // Handshake monitor. Inputs are held from just after one posedge to just after the next, so
  // valid && ready seen at the falling edge means a transfer on the coming rising edge.
  always @(negedge CLK) begin
    if (nRST && op_valid && op_ready) begin
      if (sb_q.size() > 0) begin
        sb_exp = sb_q.pop_front();
        check_eq("hs_port_a", port_a, sb_exp[67:36]);
        check_eq("hs_port_b", port_b, sb_exp[35:4]);
        check_eq("hs_aluop", {28'h0, aluop}, {28'h0, sb_exp[3:0]});
      end else begin
        check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      end
    end
  end

  initial begin
    nRST     = 1'b0;
    key_n    = 4'hF;
    sw       = 18'h00000;
    op_ready = 1'b0;
    #12;
    check_eq("rst_port_a", port_a, 32'h0);
    check_eq("rst_port_b", port_b, 32'h0);
    check_eq("rst_aluop", {28'h0, aluop}, 32'h0);
    check_eq("rst_valid", {31'h0, op_valid}, 32'h0);
    check_eq("rst_state", {30'h0, state}, 32'h0);
    tick();
    nRST = 1'b1;
    repeat (2) tick();

    // op_ready while idle does nothing
    op_ready = 1'b1;
    repeat (4) tick();
    @(negedge CLK);
    check_eq("idle_ready_valid", {31'h0, op_valid}, 32'h0);
    check_eq("idle_ready_state", {30'h0, state}, 32'h0);
    tick();
    op_ready = 1'b0;

    // Test 1: a bouncy enter gives exactly one pulse
    sw = 18'h00007;
    tick();
    key_n[0] = 1'b0;
    repeat (2) tick();
    key_n[0] = 1'b1;
    tick();
    key_n[0] = 1'b0;
    repeat (12) tick();
    key_n[0] = 1'b1;
    repeat (10) tick();
    @(negedge CLK);
    check_eq("t1_state", {30'h0, state}, 32'd1);
    check_eq("t1_port_a", port_a, 32'h0000_0007);
    check_eq("t1_port_b", port_b, 32'h0);

    // Test 8: clear in S_B
    press(4'b1000);
    @(negedge CLK);
    check_eq("t8_port_a", port_a, 32'h0);
    check_eq("t8_state", {30'h0, state}, 32'd0);

    // Test 2: full entry. The first press also measures latency from press to state update.
    sw = 18'h10005;
    tick();
    key_n = 4'b1110;
    lat = 0;
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end while (state == 2'd0 && lat < 20);
    check_eq("t2_latency", 32'(lat), 32'd7);
    repeat (4) tick();
    key_n = 4'hF;
    repeat (10) tick();
    @(negedge CLK);
    check_eq("t2_port_a", port_a, 32'hFFFF_0005);
    check_eq("t2_state_b", {30'h0, state}, 32'd1);
    sw = 18'h00003;
    press(4'b0001);
    @(negedge CLK);
    check_eq("t2_port_b", port_b, 32'h0000_0003);
    check_eq("t2_state_op", {30'h0, state}, 32'd2);
    sw = 18'h00002;
    sb_q.push_back({32'hFFFF_0005, 32'h0000_0003, 4'h2});
    press(4'b0001);
    @(negedge CLK);
    check_eq("t2_aluop", {28'h0, aluop}, 32'd2);
    check_eq("t2_valid", {31'h0, op_valid}, 32'd1);
    check_eq("t2_state_issue", {30'h0, state}, 32'd3);

    // Test 3: valid holds under backpressure, then drops after acceptance
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge CLK);
      check_eq("t3_hold_valid", {31'h0, op_valid}, 32'd1);
      check_eq("t3_hold_a", port_a, 32'hFFFF_0005);
      check_eq("t3_hold_b", port_b, 32'h0000_0003);
    end
    tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    @(negedge CLK);
    check_eq("t3_valid_low", {31'h0, op_valid}, 32'd0);
    check_eq("t3_state", {30'h0, state}, 32'd0);

    // Test 6: repeat reissues the existing set
    sb_q.push_back({32'hFFFF_0005, 32'h0000_0003, 4'h2});
    press(4'b0100);
    @(negedge CLK);
    check_eq("t6_valid", {31'h0, op_valid}, 32'd1);
    check_eq("t6_state", {30'h0, state}, 32'd3);

    // Test 5: enter during S_ISSUE is dropped
    sw = 18'h00077;
    press(4'b0001);
    @(negedge CLK);
    check_eq("t5_port_a", port_a, 32'hFFFF_0005);
    check_eq("t5_port_b", port_b, 32'h0000_0003);
    check_eq("t5_aluop", {28'h0, aluop}, 32'd2);
    check_eq("t5_state", {30'h0, state}, 32'd3);
    tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    @(negedge CLK);
    check_eq("t5_accept_state", {30'h0, state}, 32'd0);

    // Test 4: enter and cancel together in S_OP, so cancel wins
    sw = 18'h00011;
    press(4'b0001);
    sw = 18'h00022;
    press(4'b0001);
    @(negedge CLK);
    check_eq("t4_state_op", {30'h0, state}, 32'd2);
    sw = 18'h00009;
    press(4'b0011);
    @(negedge CLK);
    check_eq("t4_state", {30'h0, state}, 32'd0);
    check_eq("t4_aluop", {28'h0, aluop}, 32'd2);
    check_eq("t4_port_a", port_a, 32'h0000_0011);
    check_eq("t4_port_b", port_b, 32'h0000_0022);
    check_eq("t4_valid", {31'h0, op_valid}, 32'd0);

    // Test 7: asynchronous reset while an issue is pending
    sb_q.push_back({32'h0000_0011, 32'h0000_0022, 4'h2});
    press(4'b0100);
    @(negedge CLK);
    check_eq("t7_pre_valid", {31'h0, op_valid}, 32'd1);
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check_eq("t7_port_a", port_a, 32'h0);
    check_eq("t7_port_b", port_b, 32'h0);
    check_eq("t7_aluop", {28'h0, aluop}, 32'h0);
    check_eq("t7_valid", {31'h0, op_valid}, 32'h0);
    check_eq("t7_state", {30'h0, state}, 32'h0);
    sb_q.delete();
    tick();
    nRST = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    check_eq("t7_post_valid", {31'h0, op_valid}, 32'h0);
    check_eq("t7_post_state", {30'h0, state}, 32'h0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
